dpll_lock_det: RTL and testbench
================================

DPLL_LOCK_DET -- requirements
Module: dpll_lock_det

Interface
REQ-001 Parameter GATE_CYCLES, default 1024: measurement window length in wb_clk_i cycles.
REQ-002 Parameter CNT_W, default 12: width of the edge counter and meas_count.
REQ-003 Parameters EXP0/EXP1/EXP2/EXP3, defaults 256/128/64/32: expected fb_clk rising edges per window for freq_select 00/01/10/11.
REQ-004 Parameter TOL, default 2: allowed absolute deviation from the expected count.
REQ-005 Parameter LOCK_WINDOWS, default 4: consecutive good windows required to declare lock.
REQ-006 wb_clk_i  input  1  system clock; all logic is on the rising edge.
REQ-007 wb_rst_n  input  1  reset, synchronous, active-low.
REQ-008 enable  input  1  measurement enable.
REQ-009 freq_select  input  2  selects EXPn; same encoding as the DPLL frequency select.
REQ-010 fb_clk  input  1  DPLL output clock (io_out[0]), asynchronous to wb_clk_i, frequency below wb_clk_i/2.
REQ-011 meas_count  output  CNT_W  edge count of the last completed window.
REQ-012 meas_valid  output  1  one-cycle pulse when meas_count updates.
REQ-013 locked  output  1  DPLL lock indication.
REQ-014 lock_lost  output  1  one-cycle pulse on every 1->0 transition of locked.

Function
REQ-015 fb_clk SHALL pass through a 2-flop synchronizer; a rising edge is the synchronized value 1 with the previous synchronized value 0.
REQ-016 FSM states SHALL be IDLE, SETTLE, MEASURE and EVAL.
REQ-017 IDLE: when enable=1, go to SETTLE.
REQ-018 SETTLE: hold 3 cycles to flush the synchronizer, with no edges counted, then go to MEASURE.
REQ-019 MEASURE: count synchronized rising edges for exactly GATE_CYCLES cycles.
REQ-020 The edge counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 An edge on the last MEASURE cycle SHALL be counted.
REQ-022 EVAL (1 cycle): latch meas_count, pulse meas_valid, compute good = |count-EXPn| <= TOL, clear the edge counter, and return to MEASURE with no gap cycles.
REQ-023 The comparison SHALL use a width of CNT_W+1 bits, signed difference, so there is no underflow when count < EXPn.
REQ-024 Good window: increment good_run, saturating at LOCK_WINDOWS; locked=1 in the cycle after good_run reaches LOCK_WINDOWS.
REQ-025 Bad window: clear good_run; if locked=1, clear locked and pulse lock_lost in the same cycle.
REQ-026 A freq_select change in any state other than IDLE SHALL abort the current window, clear the edge counter and good_run, drop locked (with a lock_lost pulse if locked was 1), and go to SETTLE; no meas_valid is issued for the aborted window.
REQ-027 freq_select changing in the EVAL cycle: the abort takes priority, and that window is neither reported nor scored.
REQ-028 enable=0 in any state: go to IDLE next cycle, clear locked (with lock_lost if it was 1) and good_run; meas_count holds its last value.

Reset
REQ-029 While wb_rst_n=0 at a clock edge: state=IDLE, meas_count=0, meas_valid=0, locked=0, lock_lost=0, good_run=0, edge counter=0, gate counter=0, synchronizer flops=0.
REQ-030 Reset mid-window SHALL discard the window with no meas_valid or lock_lost pulse.

Configuration
REQ-031 Macro DPLL_LOCK_HYST_EN.
REQ-032 DPLL_LOCK_HYST_EN defined: unlock requires 2 consecutive bad windows; a single bad window clears good_run but leaves locked=1.
REQ-033 DPLL_LOCK_HYST_EN undefined: unlock follows REQ-025, i.e. on a single bad window.
REQ-034 Abort, enable=0 and reset SHALL unlock immediately in both builds.

Verification
REQ-035 Lock acquisition: wb_clk_i period 25 ns, default parameters, freq_select=00, fb_clk period 100 ns, enable=1 -> meas_count=256±1 each window; locked=1 after the 4th meas_valid.
REQ-036 Loss of lock: while locked, fb_clk period changed to 120 ns -> next window count ~213; locked=0 with a lock_lost pulse (macro off), or after the 2nd bad window (macro on).
REQ-037 Select change: while locked, freq_select 00->01 mid-window -> lock_lost pulse, no meas_valid for that window; with fb_clk period 200 ns, relock after 4 windows at count 128.
REQ-038 Saturation: CNT_W=8, fb_clk period 50 ns, GATE_CYCLES=1024 -> meas_count=255, locked stays 0.
REQ-039 Reset and enable: wb_rst_n=0 for 1 cycle mid-window -> all outputs 0 next cycle, no pulses; enable=0 while locked -> locked=0 and lock_lost pulses once.

Source files
------------

// File: rtl/dpll_lock_det.sv
`timescale 1ns/1ps
// DPLL lock detector: counts synchronized fb_clk rising edges over a GATE_CYCLES window and
// declares lock after LOCK_WINDOWS consecutive in-tolerance windows. Macro DPLL_LOCK_HYST_EN adds unlock hysteresis.
module dpll_lock_det #(
  parameter int GATE_CYCLES  = 1024,
  parameter int CNT_W        = 12,
  parameter int EXP0         = 256,
  parameter int EXP1         = 128,
  parameter int EXP2         = 64,
  parameter int EXP3         = 32,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             enable,
  input  logic [1:0]       freq_select,
  input  logic             fb_clk,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             locked,
  output logic             lock_lost
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    EVAL    = 2'd3
  } state_t;

  localparam int GW = $clog2(GATE_CYCLES + 3);
  localparam int RW = $clog2(LOCK_WINDOWS + 1);
  localparam int DW = CNT_W + 1;

  state_t           state_r, state_nx_s;
  logic             sync1_r, sync2_r, sync_prev_r;
  logic [1:0]       fsel_r;
  logic [GW-1:0]    gate_cnt_r;
  logic [CNT_W-1:0] edge_cnt_r;
  logic [RW-1:0]    good_run_r;
  logic [CNT_W-1:0] meas_count_r;
  logic             meas_valid_r, locked_r, lock_lost_r;

  logic             rise_s, abort_s, stop_s, eval_s, good_s, bad_s;
  logic             bad_unlock_s, unlock_s, settle_done_s, gate_done_s, cnt_max_s;
  logic [DW-1:0]    exp_s, diff_s, mag_s;

  assign rise_s        = sync2_r & ~sync_prev_r;
  assign abort_s       = (state_r != IDLE) && (freq_select != fsel_r);
  assign stop_s        = ~enable;
  assign eval_s        = (state_r == EVAL) && enable && !abort_s;
  assign settle_done_s = (gate_cnt_r == GW'(2));
  assign gate_done_s   = (gate_cnt_r == GW'(GATE_CYCLES - 1));
  assign cnt_max_s     = &edge_cnt_r;

  // A saturated count means the true frequency is unknown, so it never scores as good.
  assign diff_s = {1'b0, edge_cnt_r} - exp_s;
  assign mag_s  = diff_s[DW-1] ? (~diff_s + DW'(1)) : diff_s;
  assign good_s = !cnt_max_s && (mag_s <= DW'(TOL));
  assign bad_s  = eval_s && !good_s;

`ifdef DPLL_LOCK_HYST_EN
  logic bad_prev_r;

  // Remembers whether the previous scored window was bad.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      bad_prev_r <= 1'b0;
    end else if (abort_s || stop_s) begin
      bad_prev_r <= 1'b0;
    end else if (eval_s) begin
      bad_prev_r <= ~good_s;
    end
  end

  assign bad_unlock_s = bad_s && bad_prev_r;
`else
  assign bad_unlock_s = bad_s;
`endif

  assign unlock_s = abort_s || stop_s || bad_unlock_s;

  // Expected edge count for the active frequency select.
  always_comb begin
    exp_s = DW'(EXP0);
    case (fsel_r)
      2'b00:   exp_s = DW'(EXP0);
      2'b01:   exp_s = DW'(EXP1);
      2'b10:   exp_s = DW'(EXP2);
      2'b11:   exp_s = DW'(EXP3);
      default: exp_s = DW'(EXP0);
    endcase
  end

  // Next-state logic: disable beats abort, abort beats the normal sequence.
  always_comb begin
    state_nx_s = state_r;
    if (!enable) begin
      state_nx_s = IDLE;
    end else if (abort_s) begin
      state_nx_s = SETTLE;
    end else begin
      case (state_r)
        IDLE:    state_nx_s = SETTLE;
        SETTLE:  state_nx_s = settle_done_s ? MEASURE : SETTLE;
        MEASURE: state_nx_s = gate_done_s ? EVAL : MEASURE;
        EVAL:    state_nx_s = MEASURE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State register, fb_clk synchronizer and select history.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_r     <= IDLE;
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      sync_prev_r <= 1'b0;
      fsel_r      <= 2'b00;
    end else begin
      state_r     <= state_nx_s;
      sync1_r     <= fb_clk;
      sync2_r     <= sync1_r;
      sync_prev_r <= sync2_r;
      fsel_r      <= freq_select;
    end
  end

  // Gate and edge counters; both restart on every state change or abort.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      gate_cnt_r <= GW'(0);
      edge_cnt_r <= CNT_W'(0);
    end else begin
      if (abort_s || !enable || state_r == IDLE || state_nx_s != state_r) begin
        gate_cnt_r <= GW'(0);
      end else begin
        gate_cnt_r <= gate_cnt_r + GW'(1);
      end
      if (state_r != MEASURE || abort_s || !enable) begin
        edge_cnt_r <= CNT_W'(0);
      end else if (rise_s && !cnt_max_s) begin
        edge_cnt_r <= edge_cnt_r + CNT_W'(1);
      end
    end
  end

  // Window result, good-run tracking and lock outputs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      meas_count_r <= CNT_W'(0);
      meas_valid_r <= 1'b0;
      locked_r     <= 1'b0;
      lock_lost_r  <= 1'b0;
      good_run_r   <= RW'(0);
    end else begin
      meas_valid_r <= eval_s;
      lock_lost_r  <= locked_r && unlock_s;
      if (eval_s) begin
        meas_count_r <= edge_cnt_r;
      end
      if (unlock_s) begin
        locked_r <= 1'b0;
      end else if (good_run_r == RW'(LOCK_WINDOWS)) begin
        locked_r <= 1'b1;
      end
      if (abort_s || stop_s || bad_s) begin
        good_run_r <= RW'(0);
      end else if (eval_s && good_run_r != RW'(LOCK_WINDOWS)) begin
        good_run_r <= good_run_r + RW'(1);
      end
    end
  end

  assign meas_count = meas_count_r;
  assign meas_valid = meas_valid_r;
  assign locked     = locked_r;
  assign lock_lost  = lock_lost_r;

endmodule

// File: tb/tb_dpll_lock_det.sv
`timescale 1ns/1ps
// Self-checking bench for dpll_lock_det: table of lock/loss windows, hand-written select/reset/enable
// sequences, and a randomized phase scored against a window-history lock model.
module tb_dpll_lock_det;

  localparam int GATE = 1024;
  localparam int TOL  = 2;
  localparam int LW   = 4;
`ifdef DPLL_LOCK_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  freq_select = 2'b00;
  logic        fb_clk = 1'b0;
  logic        fb_sat = 1'b0;
  logic [11:0] meas_count;
  logic        meas_valid, locked, lock_lost;
  logic [7:0]  sat_count;
  logic        sat_valid, sat_locked, sat_lost;

  dpll_lock_det #(.GATE_CYCLES(GATE)) dut (
    .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .enable(enable), .freq_select(freq_select),
    .fb_clk(fb_clk), .meas_count(meas_count), .meas_valid(meas_valid),
    .locked(locked), .lock_lost(lock_lost)
  );

  dpll_lock_det #(.GATE_CYCLES(GATE), .CNT_W(8)) dut_sat (
    .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .enable(enable), .freq_select(freq_select),
    .fb_clk(fb_sat), .meas_count(sat_count), .meas_valid(sat_valid),
    .locked(sat_locked), .lock_lost(sat_lost)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ll_cnt = 0;
  int sat_mv_cnt = 0;
  logic mv_prev = 1'b0;
  logic ll_prev = 1'b0;
  int fb_period = 100;

  initial forever #12.5 clk = ~clk;
  initial begin #3; forever #(fb_period / 2) fb_clk = ~fb_clk; end
  initial begin #7; forever #25 fb_sat = ~fb_sat; end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded 3 ms");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (t=%0t)", name, act, exp, tol, $time);
    end
  endtask

  // Pulse-width, lock_lost counting and saturation checks run continuously.
  always @(negedge clk) begin
    if (mv_prev) check("valid_pulse", int'(meas_valid), 0);
    if (ll_prev) check("lost_pulse", int'(lock_lost), 0);
    if (lock_lost) ll_cnt <= ll_cnt + 1;
    if (sat_valid) begin
      sat_mv_cnt <= sat_mv_cnt + 1;
      check("sat_count", int'(sat_count), 255);
      check("sat_locked", int'(sat_locked), 0);
    end
    mv_prev <= meas_valid;
    ll_prev <= lock_lost;
  end

  // Reference model: lock state derived from the history of window verdicts.
  bit   hist_q[$];
  bit   m_locked = 1'b0;
  int   m_ll = 0;
  logic [1:0] cur_sel = 2'b00;

  function automatic int exp_for(input logic [1:0] s);
    case (s)
      2'b00:   return 256;
      2'b01:   return 128;
      2'b10:   return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int nominal(input int period);
    return (GATE * 50 + period) / (2 * period);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_window(input bit good);
    bit all_good;
    bit prev_bad;
    prev_bad = (hist_q.size() > 0) && !hist_q[hist_q.size() - 1];
    hist_q.push_back(good);
    if (hist_q.size() > LW) void'(hist_q.pop_front());
    all_good = (hist_q.size() == LW);
    foreach (hist_q[k]) if (!hist_q[k]) all_good = 1'b0;
    if (all_good) begin
      m_locked = 1'b1;
    end else if (!good && (!HYST || prev_bad)) begin
      if (m_locked) m_ll++;
      m_locked = 1'b0;
    end
  endfunction

  function automatic void model_disrupt(input bit pulse_allowed);
    if (m_locked && pulse_allowed) m_ll++;
    m_locked = 1'b0;
    hist_q.delete();
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!meas_valid && waited < budget);
    if (!meas_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL valid_timeout: no meas_valid within %0d cycles", budget);
    end
  endtask

  task automatic win_check(input int period, input int tol);
    int nom;
    nom = nominal(period);
    check_near("win_count", int'(meas_count), nom, tol);
    model_window(iabs(nom - exp_for(cur_sel)) <= TOL);
    cycles(2);
    check("win_locked", int'(locked), int'(m_locked));
    check("win_lost", ll_cnt, m_ll);
  endtask

  typedef struct {
    int period;
    int cnt;
    bit lk;
    bit lk_h;
  } vec_t;

  vec_t tab[10];
  int   tol, t0, t_prev, prev_p, p, act;
  logic [1:0] ns;

  initial begin
    tab[0] = '{100, 256, 1'b0, 1'b0};
    tab[1] = '{100, 256, 1'b0, 1'b0};
    tab[2] = '{100, 256, 1'b0, 1'b0};
    tab[3] = '{100, 256, 1'b1, 1'b1};
    tab[4] = '{120, 213, 1'b0, 1'b1};
    tab[5] = '{120, 213, 1'b0, 1'b0};
    tab[6] = '{100, 256, 1'b0, 1'b0};
    tab[7] = '{100, 256, 1'b0, 1'b0};
    tab[8] = '{100, 256, 1'b0, 1'b0};
    tab[9] = '{100, 256, 1'b1, 1'b1};

    cycles(5);
    check("rst_count", int'(meas_count), 0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_lost", int'(lock_lost), 0);
    wb_rst_n = 1'b1;
    enable   = 1'b1;

    // Lock acquisition and loss of lock.
    prev_p = 100;
    t_prev = 0;
    for (int i = 0; i < 10; i++) begin
      fb_period = tab[i].period;
      tol = (tab[i].period != prev_p) ? 2 : 1;
      wait_valid(1200);
      check_near("tab_count", int'(meas_count), tab[i].cnt, tol);
      if (i > 0) check("tab_spacing", cyc - t_prev, GATE + 1);
      t_prev = cyc;
      model_window(iabs(tab[i].cnt - 256) <= TOL);
      cycles(2);
      check("tab_locked", int'(locked), int'(HYST ? tab[i].lk_h : tab[i].lk));
      check("tab_lost", ll_cnt, m_ll);
      prev_p = tab[i].period;
    end

    // Select change mid-window while locked, then relock at 128.
    cycles(500);
    t0 = cyc;
    freq_select = 2'b01;
    cur_sel = 2'b01;
    fb_period = 200;
    model_disrupt(1'b1);
    cycles(3);
    check("sel_locked", int'(locked), 0);
    check("sel_lost", ll_cnt, m_ll);
    wait_valid(1300);
    n_cmp++;
    if (cyc - t0 < GATE + 3 || cyc - t0 > GATE + 8) begin
      n_fail++;
      $display("FAIL sel_gap: first report %0d cycles after abort, expected %0d..%0d", cyc - t0, GATE + 3, GATE + 8);
    end
    win_check(200, 1);
    for (int j = 0; j < 3; j++) begin
      wait_valid(1200);
      win_check(200, 1);
    end
    check("sel_relock", int'(locked), 1);

    // One-cycle reset mid-window while locked: no pulses, all outputs cleared.
    cycles(400);
    wb_rst_n = 1'b0;
    cycles(1);
    wb_rst_n = 1'b1;
    check("mrst_count", int'(meas_count), 0);
    check("mrst_valid", int'(meas_valid), 0);
    check("mrst_locked", int'(locked), 0);
    check("mrst_lost", int'(lock_lost), 0);
    model_disrupt(1'b0);
    cycles(3);
    check("mrst_nopulse", ll_cnt, m_ll);
    for (int j = 0; j < 4; j++) begin
      wait_valid(1300);
      win_check(200, 1);
    end

    // enable=0 while locked.
    cycles(300);
    enable = 1'b0;
    model_disrupt(1'b1);
    cycles(3);
    check("en_locked", int'(locked), 0);
    check("en_lost", ll_cnt, m_ll);
    check_near("en_hold", int'(meas_count), 128, 1);
    enable = 1'b1;
    wait_valid(1300);
    win_check(200, 1);

    // Randomized windows, aborts and enable drops.
    for (int r = 0; r < 14; r++) begin
      act = $urandom_range(0, 9);
      if (act <= 6) begin
        if ($urandom_range(0, 9) < 7) p = 100 << cur_sel;
        else p = (50 << $urandom_range(0, 4)) + (($urandom_range(0, 3) == 0) ? 20 : 0);
        tol = (p != fb_period) ? 2 : 1;
        fb_period = p;
        wait_valid(1200);
        win_check(p, tol);
      end else if (act <= 8) begin
        cycles($urandom_range(100, 800));
        ns = cur_sel + 2'($urandom_range(1, 3));
        cur_sel = ns;
        freq_select = ns;
        p = ($urandom_range(0, 3) != 0) ? (100 << ns) : 120;
        fb_period = p;
        model_disrupt(1'b1);
        cycles(3);
        check("rnd_abort_locked", int'(locked), int'(m_locked));
        check("rnd_abort_lost", ll_cnt, m_ll);
        wait_valid(1300);
        win_check(p, 1);
      end else begin
        cycles($urandom_range(100, 800));
        enable = 1'b0;
        model_disrupt(1'b1);
        cycles($urandom_range(3, 5));
        check("rnd_en_locked", int'(locked), int'(m_locked));
        check("rnd_en_lost", ll_cnt, m_ll);
        enable = 1'b1;
        wait_valid(1300);
        win_check(fb_period, 1);
      end
    end

    check("sat_final_locked", int'(sat_locked), 0);
    check("sat_seen", int'(sat_mv_cnt > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
